// File: rtl/btn_start_conditioner.sv
// Start-button conditioner: 2-FF synchroniser, counter debouncer, edge/long-press pulses
// and a held start request cleared by req_ack.
module btn_start_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 200_000_000,
  parameter int unsigned CNT_W             = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic req_ack,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic start_req,
  output logic press_dropped
);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {StReleased, StPressed, StLongHeld} state_e;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             start_req_q, start_req_d;
  logic             dropped_q, dropped_d;
  logic             rise, fall;

  // Debouncer: any sample matching the current level restarts the count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = sync2_q;
        rise    = sync2_q;
        fall    = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CntOne;
      end
    end
    press_d   = rise;
    release_d = fall;
  end

  // Hold tracker: long press fires once, counter stops at its terminal value.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    case (state_q)
      StReleased: begin
        if (rise) begin
          state_d    = StPressed;
          hold_cnt_d = '0;
        end
      end
      StPressed: begin
        if (fall) begin
          state_d = StReleased;
        end else if (hold_cnt_q == LongLast) begin
          state_d = StLongHeld;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CntOne;
        end
      end
      StLongHeld: begin
        if (fall) state_d = StReleased;
      end
      default: state_d = StReleased;
    endcase
  end

  // A press coinciding with an ack re-arms the request instead of being dropped.
  always_comb begin
    start_req_d = start_req_q;
    dropped_d   = 1'b0;
    if (start_req_q && req_ack) start_req_d = 1'b0;
    if (press_q) begin
      if (start_req_q && !req_ack) begin
        dropped_d = 1'b1;
      end else begin
        start_req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      state_q     <= StReleased;
      hold_cnt_q  <= '0;
      start_req_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      start_req_q <= start_req_d;
      dropped_q   <= dropped_d;
    end
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign start_req        = start_req_q;
  assign press_dropped    = dropped_q;

endmodule

// File: tb/tb_btn_start_conditioner.sv
// Bench for btn_start_conditioner: expected output vectors are queued as stimulus is
// driven and compared on the following falling edge.
module tb_btn_start_conditioner;

  logic clk = 1'b0;
  logic rst, btn_raw, req_ack;
  logic btn_level, press_pulse, release_pulse, long_press_pulse, start_req, press_dropped;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  btn_start_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .CNT_W            (28)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .btn_raw         (btn_raw),
    .req_ack         (req_ack),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .start_req       (start_req),
    .press_dropped   (press_dropped)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Output vector: {level, press, release, long, start_req, dropped}
  function automatic logic [5:0] vec(input logic lvl, input logic pr, input logic rl,
                                     input logic lg, input logic sr, input logic dr);
    return {lvl, pr, rl, lg, sr, dr};
  endfunction

  // Expectation is for the state right after the edge just waited on; inputs change after it.
  task automatic step(input logic raw, input logic ack, input logic rst_v,
                      input logic [5:0] exp, input string tag);
    sb_item_t item;
    @(posedge clk);
    #1;
    btn_raw = raw;
    req_ack = ack;
    rst     = rst_v;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_item_t item;
      item = sb_q.pop_front();
      check_eq(item.tag, 32'({btn_level, press_pulse, release_pulse, long_press_pulse,
                              start_req, press_dropped}), 32'(item.exp));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b0;
    req_ack = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 6'b0, $sformatf("reset[%0d]", i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 6'b0, $sformatf("idle[%0d]", i));

    // Clean press held long enough for exactly one long-press pulse.
    for (int i = 0; i <= 40; i++)
      step(1'b1, 1'b0, 1'b0, vec(i >= 6, i == 6, 1'b0, i == 26, i >= 7, 1'b0),
           $sformatf("press1[%0d]", i));
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b0, 1'b0, vec(j < 6, 1'b0, j == 6, 1'b0, 1'b1, 1'b0),
           $sformatf("release1[%0d]", j));

    // Second press while the request is still pending.
    for (int k = 0; k < 10; k++)
      step(1'b1, 1'b0, 1'b0, vec(k >= 6, k == 6, 1'b0, 1'b0, 1'b1, k == 7),
           $sformatf("dropped[%0d]", k));
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b0, 1'b0, vec(j < 6, 1'b0, j == 6, 1'b0, 1'b1, 1'b0),
           $sformatf("release2[%0d]", j));

    // Single ack clears the request; held ack with no request does nothing.
    for (int m = 0; m < 6; m++)
      step(1'b0, 1'b1, 1'b0, vec(1'b0, 1'b0, 1'b0, 1'b0, m == 0, 1'b0),
           $sformatf("ack[%0d]", m));
    step(1'b0, 1'b0, 1'b0, 6'b0, "ack_idle");

    // Bounce: 1,0,1,1,0 then steady 1; last rise is at step 5.
    for (int b = 0; b < 16; b++)
      step((b < 5) ? ((5'b01101 >> b) & 5'b1) != 0 : 1'b1, 1'b0, 1'b0,
           vec(b >= 11, b == 11, 1'b0, 1'b0, b >= 12, 1'b0), $sformatf("bounce[%0d]", b));
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b0, 1'b0, vec(j < 6, 1'b0, j == 6, 1'b0, 1'b1, 1'b0),
           $sformatf("release3[%0d]", j));

    // Press with ack coincident with press_pulse, then a 3-cycle low glitch while held.
    for (int k = 0; k <= 30; k++)
      step(!(k >= 10 && k <= 12), k == 6, 1'b0,
           vec(k >= 6, k == 6, 1'b0, k == 26, 1'b1, 1'b0), $sformatf("coinc[%0d]", k));

    // Reset for two cycles in the long-held state with the button still down.
    for (int r = 0; r <= 30; r++)
      step(1'b1, 1'b0, r == 0 || r == 1,
           (r == 0) ? vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)
                    : vec(r >= 8, r == 8, 1'b0, r == 28, r >= 9, 1'b0),
           $sformatf("rst_mid[%0d]", r));
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b0, 1'b0, vec(j < 6, 1'b0, j == 6, 1'b0, 1'b1, 1'b0),
           $sformatf("release4[%0d]", j));
    step(1'b0, 1'b1, 1'b0, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "final_ack");
    step(1'b0, 1'b0, 1'b0, 6'b0, "final_idle");

    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_start_conditioner.md
Name: btn_start_conditioner

Overview:
Upstream conditioning stage for the traffic-light controller's start input. It takes the raw, asynchronous, bouncy push-button and synchronises and debounces it. It then produces a clean level, single-cycle press/release/long-press pulses, and a held start request with an acknowledge handshake that the light controller consumes. All logic runs on the 100 MHz system clock.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to accept a level change (10 ms @ 100 MHz); minimum 2
LONG_PRESS_CYCLES, 200_000_000, debounced-high duration that qualifies as a long press (2 s); must exceed DEBOUNCE_CYCLES
CNT_W, 28, width of both internal counters; must hold LONG_PRESS_CYCLES

Ports:
clk  input  1  system clock, 100 MHz; the only clock
rst  input  1  synchronous, active-high reset
btn_raw  input  1  raw push-button pin, asynchronous to clk, may bounce
req_ack  input  1  downstream accepts the start request (single cycle or held)
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on each debounced rising edge
release_pulse  output  1  one-cycle pulse on each debounced falling edge
long_press_pulse  output  1  one-cycle pulse once per press held LONG_PRESS_CYCLES
start_req  output  1  start request, held high until acknowledged
press_dropped  output  1  one-cycle pulse when a press arrives while start_req is already high

Behaviour:
- Reset (sync, rst high at a clk edge): synchroniser FFs, btn_level, all pulses, start_req, press_dropped = 0; both counters = 0; FSM = RELEASED. Reset mid-press clears everything. After reset, a still-held button must be re-debounced from 0 and produces press_pulse normally.
- Synchroniser: 2-FF chain on btn_raw giving btn_sync. No other logic may sample btn_raw.
- Debounce: counter db_cnt.
  - When btn_sync != btn_level, db_cnt increments.
  - When btn_sync == btn_level, db_cnt clears to 0.
  - When db_cnt == DEBOUNCE_CYCLES-1 and btn_sync still differs, btn_level <= btn_sync and db_cnt <= 0.
  - Any bounce back to the old level before acceptance restarts the count.
- Latency: btn_raw steady high from the sampling edge E0 -> btn_level high at edge E0 + 2 + DEBOUNCE_CYCLES. Release latency is the same.
- press_pulse and release_pulse are registered and asserted in the same cycle btn_level first shows the new value, for exactly 1 cycle.
- FSM states:
  - RELEASED: on debounced rise -> PRESSED, hold_cnt <= 0.
  - PRESSED: hold_cnt increments each cycle. When hold_cnt == LONG_PRESS_CYCLES-1 -> LONG_HELD and long_press_pulse = 1 for that cycle. Debounced fall -> RELEASED.
  - LONG_HELD: no further pulses, hold_cnt frozen. Debounced fall -> RELEASED.
  - Long press fires at most once per press; hold_cnt saturates and never wraps.
- Start request handshake:
  - press_pulse with start_req low: start_req <= 1 on the next edge.
  - start_req stays high until a cycle with req_ack high, then clears on the following edge.
  - req_ack while start_req is low is ignored.
  - press_pulse while start_req is high: no new request is queued; press_dropped pulses 1 cycle.
  - press_pulse and req_ack in the same cycle with start_req high: ack clears the old request, and the new press re-sets start_req. Net result: start_req stays 1 and press_dropped = 0.
- A long press does not generate a start request; only the rising edge does.
- Pulses never overlap: press and release are always separated by at least DEBOUNCE_CYCLES cycles.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.)
1. Clean press: btn_raw 0->1 at E0, held 40 cycles -> btn_level and press_pulse high at E0+6 (press_pulse 1 cycle); start_req high at E0+7; long_press_pulse once at E0+6+20; no second pulse.
2. Bounce: btn_raw toggles 1,0,1,1,0 per cycle, then steady 1 -> btn_level rises exactly 6 cycles after the last 0->1 transition; exactly one press_pulse.
3. Handshake: start_req high, req_ack pulsed 1 cycle at edge T -> start_req 0 from T+1. req_ack held with no request -> start_req stays 0.
4. Dropped press: start_req pending, second debounced press -> press_dropped 1 cycle, start_req stays 1. Repeat with req_ack coincident with press_pulse -> start_req stays 1, press_dropped 0.
5. Reset mid-operation: rst asserted 2 cycles during LONG_HELD with the button held -> all outputs 0 next edge. After rst deasserts, press_pulse reappears 6 cycles later.
6. Short release glitch: button held, btn_raw low for 3 cycles -> btn_level stays 1, no release_pulse, hold_cnt continues.
